// File: rtl/serial_rx_deser_pkg.sv
// Shared types and constants for the serial_rx_deser frame receiver.
// The optional even-parity bit is enabled with the PARITY_CHECK_EN macro.
package serial_rx_deser_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DATA      = 3'd1,
    PARITY    = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  // Bit-counter width for a given word width; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_rx_deser_shift_reg.sv
// WIDTH-bit serial-in right-shift register with synchronous clear.
// New bits enter at the MSB, so after WIDTH shifts the first bit sits in q[0].
module rx_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             shift,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (clear) begin
      q <= '0;
    end else if (shift) begin
      q <= {din, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/serial_rx_deser.sv
// LSB-first serial frame receiver with a valid/ready parallel output port.
// Define PARITY_CHECK_EN to expect one even-parity bit between data and stop.
module serial_rx_deser
  import serial_rx_deser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_en,
  input  logic             SI,
  input  logic             ready,
  output logic [WIDTH-1:0] Q,
  output logic             valid,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun
);

  localparam int CW = cnt_width(WIDTH);

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [WIDTH-1:0] sr;
  logic            shift;
  logic            done, ferr, perr;
  logic            par_ok;

  rx_shift_reg #(.WIDTH(WIDTH)) u_sr (
    .clk   (clk),
    .clear (reset),
    .shift (shift),
    .din   (SI),
    .q     (sr)
  );

`ifdef PARITY_CHECK_EN
  logic par_bit;

  always_ff @(posedge clk) begin
    if (reset) begin
      par_bit <= 1'b0;
    end else if (bit_en && state == PARITY) begin
      par_bit <= SI;
    end
  end

  // Even parity: data bits plus parity bit must XOR to zero.
  assign par_ok = (par_bit == ^sr);
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    shift      = 1'b0;
    done       = 1'b0;
    ferr       = 1'b0;
    perr       = 1'b0;
    if (bit_en) begin
      case (state)
        IDLE: begin
          if (!SI) begin
            state_next = DATA;
            cnt_next   = '0;
          end
        end
        DATA: begin
          shift    = 1'b1;
          cnt_next = cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
`ifdef PARITY_CHECK_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
        PARITY: state_next = STOP;
        STOP: begin
          if (!SI) begin
            ferr       = 1'b1;
            state_next = WAIT_IDLE;
          end else if (par_ok) begin
            done       = 1'b1;
            state_next = IDLE;
          end else begin
            perr       = 1'b1;
            state_next = IDLE;
          end
        end
        WAIT_IDLE: begin
          if (SI) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Output port: a completion beats a same-cycle transfer; a held word is never overwritten.
  always_ff @(posedge clk) begin
    if (reset) begin
      Q          <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= ferr;
      parity_err <= perr;
      if (done) begin
        if (!valid || ready) begin
          Q     <= sr;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_rx_deser.sv
// Randomized scoreboard bench for serial_rx_deser (WIDTH=4).
// Builds with or without PARITY_CHECK_EN; the frame format follows the macro.
module tb_serial_rx_deser;

  localparam int W = 4;
  localparam logic [1:0] K_GOOD = 2'd0;
  localparam logic [1:0] K_FERR = 2'd1;
  localparam logic [1:0] K_PERR = 2'd2;

  logic         clk = 1'b0;
  logic         reset, bit_en, SI, ready;
  logic [W-1:0] Q;
  logic         valid, frame_err, parity_err, overrun;

  serial_rx_deser #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .bit_en     (bit_en),
    .SI         (SI),
    .ready      (ready),
    .Q          (Q),
    .valid      (valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Driver -> model side channel describing the stop sample of the current cycle.
  logic         stop_now  = 1'b0;
  logic [1:0]   stop_kind = K_GOOD;
  logic [W-1:0] stop_word = '0;
  int           rdy_mode  = 0;  // 0 low, 1 high, 2 random, 3 high only on stop samples

  // Reference model state
  logic         mv = 1'b0, ovr = 1'b0, ferr_due = 1'b0, perr_due = 1'b0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: compare registered outputs against what the previous cycle predicted, then advance.
  always @(negedge clk) begin
    check("valid", {31'd0, valid}, {31'd0, mv});
    check("overrun", {31'd0, overrun}, {31'd0, ovr});
    check("frame_err", {31'd0, frame_err}, {31'd0, ferr_due});
    check("parity_err", {31'd0, parity_err}, {31'd0, perr_due});
    if (reset) begin
      mv = 1'b0; ovr = 1'b0; ferr_due = 1'b0; perr_due = 1'b0;
      exp_q.delete();
    end else begin
      ferr_due = 1'b0;
      perr_due = 1'b0;
      if (mv && ready) mv = 1'b0;
      if (bit_en && stop_now) begin
        case (stop_kind)
          K_GOOD: begin
            if (!mv) begin
              mv = 1'b1;
              exp_q.push_back(stop_word);
            end else begin
              ovr = 1'b1;
            end
          end
          K_FERR:  ferr_due = 1'b1;
          default: perr_due = 1'b1;
        endcase
      end
    end
  end

  // Monitor: every transfer must deliver the oldest accepted word.
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    if (!reset && valid && ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", {28'd0, Q}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("word", {28'd0, Q}, {28'd0, e});
      end
    end
  end

  task automatic tick(input logic be, input logic si, input logic stp,
                      input logic [1:0] kind, input logic [W-1:0] word);
    @(posedge clk); #1;
    bit_en = be; SI = si; stop_now = stp; stop_kind = kind; stop_word = word;
    case (rdy_mode)
      0:       ready = 1'b0;
      1:       ready = 1'b1;
      2:       ready = ($urandom_range(0, 2) == 0);
      default: ready = stp;
    endcase
  endtask

  task automatic sample(input logic si, input logic stp, input logic [1:0] kind,
                        input logic [W-1:0] word);
    tick(1'b1, si, stp, kind, word);
    repeat (3) tick(1'b0, si, 1'b0, K_GOOD, '0);
  endtask

  task automatic send_frame(input logic [W-1:0] data, input logic stop, input logic par_good);
    logic [1:0] kind;
    logic       pg;
`ifdef PARITY_CHECK_EN
    pg = par_good;
`else
    pg = 1'b1;
`endif
    kind = !stop ? K_FERR : (!pg ? K_PERR : K_GOOD);
    sample(1'b0, 1'b0, K_GOOD, '0);
    for (int i = 0; i < W; i++) sample(data[i], 1'b0, K_GOOD, '0);
`ifdef PARITY_CHECK_EN
    sample((^data) ^ !pg, 1'b0, K_GOOD, '0);
`endif
    sample(stop, 1'b1, kind, data);
    if (!stop) begin
      sample(1'b0, 1'b0, K_GOOD, '0);  // must not start a frame from WAIT_IDLE
      sample(1'b1, 1'b0, K_GOOD, '0);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; bit_en = 1'b0; SI = 1'b1; stop_now = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    check("reset_Q", {28'd0, Q}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; bit_en = 1'b0; SI = 1'b1; ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("init_Q", {28'd0, Q}, 32'd0);
    check("init_valid", {31'd0, valid}, 32'd0);

    // Good frame 0xA, then consume it
    rdy_mode = 0;
    send_frame(4'hA, 1'b1, 1'b1);
    check("t1_Q", {28'd0, Q}, 32'hA);
    rdy_mode = 1;
    repeat (2) tick(1'b0, 1'b1, 1'b0, K_GOOD, '0);
    rdy_mode = 0;

    // Bad stop bit: Q keeps the last word
    send_frame(4'hF, 1'b0, 1'b1);
    check("t2_Q", {28'd0, Q}, 32'hA);

    // Overrun: second word dropped while the first is unconsumed
    send_frame(4'h3, 1'b1, 1'b1);
    send_frame(4'hC, 1'b1, 1'b1);
    check("t3_Q", {28'd0, Q}, 32'h3);
    rdy_mode = 1;
    repeat (2) tick(1'b0, 1'b1, 1'b0, K_GOOD, '0);
    rdy_mode = 0;
    do_reset();

    // Completion and transfer in the same cycle
    rdy_mode = 3;
    send_frame(4'h6, 1'b1, 1'b1);
    send_frame(4'h9, 1'b1, 1'b1);
    check("t4_Q", {28'd0, Q}, 32'h9);
    rdy_mode = 1;
    repeat (2) tick(1'b0, 1'b1, 1'b0, K_GOOD, '0);

`ifdef PARITY_CHECK_EN
    send_frame(4'hA, 1'b1, 1'b1);
    send_frame(4'hB, 1'b1, 1'b0);
    repeat (2) tick(1'b0, 1'b1, 1'b0, K_GOOD, '0);
`endif

    // Reset after the second data sample, then a fresh frame
    sample(1'b0, 1'b0, K_GOOD, '0);
    sample(1'b1, 1'b0, K_GOOD, '0);
    sample(1'b0, 1'b0, K_GOOD, '0);
    do_reset();
    rdy_mode = 0;
    send_frame(4'h5, 1'b1, 1'b1);
    check("t6_Q", {28'd0, Q}, 32'h5);

    // Randomized traffic
    rdy_mode = 2;
    for (int f = 0; f < 150; f++) begin
      logic [W-1:0] d;
      d = W'($urandom_range(0, (1 << W) - 1));
      send_frame(d, $urandom_range(0, 7) != 0, $urandom_range(0, 5) != 0);
      repeat ($urandom_range(0, 2)) sample(1'b1, 1'b0, K_GOOD, '0);
    end

    rdy_mode = 1;
    repeat (10) tick(1'b0, 1'b1, 1'b0, K_GOOD, '0);
    check("drain_empty", exp_q.size(), 32'd0);
    check("drain_valid", {31'd0, valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
